// File: rtl/seg_sched_pkg.sv
// Shared types and helpers for the segment display scheduler.
// Code width, blank code, state encoding, one-hot test.
package seg_sched_pkg;

  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] BLANK_CODE = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AUTO   = 2'd1,
    MANUAL = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [CODE_W-1:0] code);
    return (code != '0) && ((code & (code - CODE_W'(1))) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] idx_to_code(input logic [2:0] idx);
    return CODE_W'(1) << idx;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running terminal counter: counts 0..LIMIT-1 while advance is high.
// Wrap is combinational on the last advancing cycle; clear has priority over advance.
module dwell_timer #(
  parameter int LIMIT = 4,
  parameter int CNT_W = $clog2(LIMIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_end;

  assign w_at_end = (r_count == CNT_W'(LIMIT - 1));
  assign wrap     = advance & w_at_end;
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (advance) begin
      r_count <= w_at_end ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_display_sched.sv
// Time-shares the one-hot segment decoder between an auto stepper and a manual port.
// Accept -> display in 1 cycle; req_ready drops only while the 1-entry pending buffer is full.
module seg_display_sched
  import seg_sched_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000000,
  parameter int HOLD_CYCLES  = 2000000,
  parameter int NUM_CODES    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              auto_en,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  output logic [CODE_W-1:0] disp_code,
  output logic              disp_src,
  output logic              tick,
  output logic              err
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES);

  state_t            r_state;
  logic [2:0]        r_auto_idx;
  logic [CODE_W-1:0] r_disp_code;
  logic              r_disp_src;
  logic              r_tick;
  logic              r_err;
  logic              r_pend_vld;
  logic [CODE_W-1:0] r_pend_code;

  state_t            w_state_nxt;
  logic [2:0]        w_idx_nxt;
  logic [2:0]        w_idx_inc;
  logic [CODE_W-1:0] w_disp_nxt;
  logic              w_src_nxt;
  logic              w_tick_nxt;
  logic              w_err_nxt;
  logic              w_pend_vld_nxt;
  logic [CODE_W-1:0] w_pend_code_nxt;

  logic              w_accept;
  logic              w_acc_ok;
  logic              w_acc_bad;
  logic              w_dwell_adv;
  logic              w_dwell_clr;
  logic              w_dwell_wrap;
  logic              w_hold_adv;
  logic              w_hold_clr;
  logic              w_hold_wrap;
  logic [DWELL_W-1:0] w_dwell_cnt_unused;
  logic [HOLD_W-1:0]  w_hold_cnt_unused;

  assign req_ready = en & ~r_pend_vld;
  assign w_accept  = req_valid & req_ready;
  assign w_acc_ok  = w_accept & is_onehot(req_code);
  assign w_acc_bad = w_accept & ~is_onehot(req_code);
  assign w_idx_inc = (r_auto_idx == 3'(NUM_CODES - 1)) ? 3'd0 : r_auto_idx + 3'd1;

  // Timers restart whenever their state is left, so any re-entry begins a full period.
  assign w_dwell_adv = en & (r_state == AUTO);
  assign w_dwell_clr = en & (w_state_nxt != AUTO);
  assign w_hold_adv  = en & (r_state == MANUAL);
  assign w_hold_clr  = en & (w_state_nxt != MANUAL);

  dwell_timer #(.LIMIT(DWELL_CYCLES)) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_dwell_clr),
    .advance (w_dwell_adv),
    .count   (w_dwell_cnt_unused),
    .wrap    (w_dwell_wrap)
  );

  dwell_timer #(.LIMIT(HOLD_CYCLES)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_hold_clr),
    .advance (w_hold_adv),
    .count   (w_hold_cnt_unused),
    .wrap    (w_hold_wrap)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_auto_idx;
    w_disp_nxt      = r_disp_code;
    w_src_nxt       = r_disp_src;
    w_tick_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_code_nxt = r_pend_code;
    if (en) begin
      w_err_nxt = w_acc_bad;
      unique case (r_state)
        IDLE: begin
          if (w_acc_ok) begin
            w_state_nxt = MANUAL;
            w_disp_nxt  = req_code;
            w_src_nxt   = 1'b1;
          end else if (auto_en) begin
            w_state_nxt = AUTO;
            w_disp_nxt  = idx_to_code(r_auto_idx);
          end else begin
            w_disp_nxt  = BLANK_CODE;
          end
        end
        AUTO: begin
          // Manual beats a same-cycle auto wrap; that step is simply lost.
          if (w_acc_ok) begin
            w_state_nxt = MANUAL;
            w_disp_nxt  = req_code;
            w_src_nxt   = 1'b1;
          end else if (!auto_en) begin
            w_state_nxt = IDLE;
            w_disp_nxt  = BLANK_CODE;
          end else if (w_dwell_wrap) begin
            w_idx_nxt  = w_idx_inc;
            w_disp_nxt = idx_to_code(w_idx_inc);
            w_tick_nxt = 1'b1;
          end
        end
        MANUAL: begin
          if (w_hold_wrap) begin
            if (r_pend_vld) begin
              w_disp_nxt     = r_pend_code;
              w_pend_vld_nxt = 1'b0;
            end else if (w_acc_ok) begin
              w_disp_nxt = req_code;
            end else if (auto_en) begin
              w_state_nxt = AUTO;
              w_disp_nxt  = idx_to_code(r_auto_idx);
              w_src_nxt   = 1'b0;
            end else begin
              w_state_nxt = IDLE;
              w_disp_nxt  = BLANK_CODE;
              w_src_nxt   = 1'b0;
            end
          end else if (w_acc_ok) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_code_nxt = req_code;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_disp_nxt  = BLANK_CODE;
          w_src_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_auto_idx  <= 3'd0;
      r_disp_code <= BLANK_CODE;
      r_disp_src  <= 1'b0;
      r_tick      <= 1'b0;
      r_err       <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= BLANK_CODE;
    end else begin
      r_state     <= w_state_nxt;
      r_auto_idx  <= w_idx_nxt;
      r_disp_code <= w_disp_nxt;
      r_disp_src  <= w_src_nxt;
      r_tick      <= w_tick_nxt;
      r_err       <= w_err_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_code <= w_pend_code_nxt;
    end
  end

  assign disp_code = r_disp_code;
  assign disp_src  = r_disp_src;
  assign tick      = r_tick;
  assign err       = r_err;

endmodule

// File: doc/seg_display_sched.md
Name: seg_display_sched

Overview:
- Scheduler that time-shares the one-hot-to-7-segment decoder between two requesters: an internal auto-stepping pattern generator and an external manual request port.
- Sequences which one-hot code drives the decoder's 8-bit input. All-zero means blank.
- Sits between the input pins/registers and the combinational segment decoder in the top-level wrapper.

Parameters:
- DWELL_CYCLES, 1000000, clock cycles each auto code stays displayed (>=2)
- HOLD_CYCLES, 2000000, clock cycles a manual code stays displayed (>=2)
- NUM_CODES, 8, number of auto codes stepped through (2..8)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: one clock; asynchronous, active-low
- en  in  1  global enable; low freezes all state
- auto_en  in  1  enables the auto-stepping requester
- req_valid  in  1  manual request valid
- req_code  in  8  manual one-hot code
- req_ready  out  1  manual request may be accepted this cycle
- disp_code  out  8  registered code to decoder; 0 = blank
- disp_src  out  1  0 = auto/idle, 1 = manual
- tick  out  1  one-cycle pulse on each auto step
- err  out  1  one-cycle pulse: rejected non-one-hot request

Behaviour:
- Reset (async assert, sync release) sets:
  - disp_code=0, disp_src=0, tick=0, err=0
  - state=IDLE, auto_idx=0, dwell_cnt=0, hold_cnt=0, pending empty
  - req_ready is 1 once rst_n=1 and en=1.
- req_ready = en & !pending_full. It is combinational from registered state.
- A request is accepted when req_valid & req_ready.
- en=0: no counter advances, no state change, no acceptance. All outputs hold, tick and err are 0.
- IDLE:
  - disp_code=0.
  - auto_en=1 → AUTO. Next cycle disp_code=1<<auto_idx, dwell_cnt=0.
- AUTO:
  - dwell_cnt increments each cycle.
  - When dwell_cnt==DWELL_CYCLES-1: dwell_cnt→0, auto_idx→(auto_idx+1) mod NUM_CODES, disp_code updates on the same edge, tick pulses for 1 cycle.
  - auto_en=0 → IDLE. dwell_cnt is cleared and auto_idx is retained.
- Accepted valid request (exactly one bit set) in IDLE/AUTO:
  - Next cycle: state MANUAL, disp_code=req_code, disp_src=1, hold_cnt=0.
  - AUTO progress pauses and auto_idx is retained.
  - Manual has strict priority: it wins over an auto wrap in the same cycle, and that auto step is dropped.
- MANUAL:
  - hold_cnt increments each cycle.
  - An accepted valid request is stored in the 1-entry pending buffer.
  - At hold_cnt==HOLD_CYCLES-1:
    - pending full → disp_code=pending, pending cleared, hold_cnt=0.
    - else an accepted request in that cycle → displayed directly, hold_cnt=0.
    - else → AUTO if auto_en (disp_code=1<<auto_idx, dwell_cnt=0, disp_src=0), otherwise IDLE (disp_code=0, disp_src=0).
- Invalid request (req_code==0 or more than 1 bit set):
  - The handshake still completes.
  - err=1 on the next cycle only.
  - No state, display or pending change.
- Latency: acceptance → disp_code update is exactly 1 cycle.
- Width rules:
  - Counters are $clog2 of the respective parameter.
  - auto_idx is 3 bits and wraps at NUM_CODES-1.
- Reset mid-operation: immediate return to reset values. A pending entry is discarded.

Decomposition:
- Package seg_sched_pkg holds:
  - state enum {IDLE, AUTO, MANUAL}
  - CODE_W=8
  - BLANK_CODE=8'h00
  - function is_onehot(code)
- One sub-module, dwell_timer, instantiated twice (dwell and hold):
  - Parameters: LIMIT.
  - Inputs: clear, advance.
  - Outputs: count, wrap pulse.

Test Plan (DWELL_CYCLES=4, HOLD_CYCLES=3, NUM_CODES=8):
- Reset, en=1, auto_en=1 → disp_code 01,02,04,… each held 4 cycles, tick every 4th cycle; after 80 wraps back to 01.
- In AUTO at code 04, accept req_code=8'h20 → next cycle disp_code=20, disp_src=1, held 3 cycles; then disp_code=04 with full 4-cycle dwell.
- During MANUAL, accept 8'h10 then present 8'h40 → req_ready=0 while pending full; 10 shown after first hold; 40 accepted only once ready returns high.
- req_code=8'h03, then 8'h00 → each accepted, err pulses one cycle after each, disp_code unchanged.
- en=0 for 5 cycles mid-dwell → disp_code, counters and tick frozen; dwell resumes from the same count.
- Assert rst_n low mid-MANUAL with pending full → disp_code=0 asynchronously; after release, IDLE, no pending code ever displayed.
